// File: rtl/ddr3_dfi_responder.sv
// rtl/ddr3_dfi_responder.sv - DFI-side DDR3 responder: bank tracking, burst queues, word storage, read latency pipe
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   dfi_address_i/bank_i         row (ACT), column (RD/WR), A10 precharge-all (PRE); bank select
//   dfi_cs_n/ras_n/cas_n/we_n_i  command strobes
//   dfi_cke_i/odt_i/reset_n_i    clock enable, ODT (unused), DRAM reset (active-low)
//   dfi_wrdata_i/_en_i/_mask_i   write beat, beat valid, per-byte mask (1 = keep old byte)
//   dfi_rddata_en_i              read beat request
//   dfi_rddata_o/_valid_o/_dnv_o read beat, valid, data-not-valid (always 0)
//   err_o                        sticky errors: [0] ACT open bank, [1] RD/WR closed bank,
//                                [2] REF/MRS with bank open, [3] queue overflow / beat on empty queue
module ddr3_dfi_responder #(
   parameter int DDR_READ_LATENCY = 4,
   parameter int MEM_ADDR_W       = 10
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [14:0] dfi_address_i,
   input  logic [2:0]  dfi_bank_i,
   input  logic        dfi_cs_n_i,
   input  logic        dfi_ras_n_i,
   input  logic        dfi_cas_n_i,
   input  logic        dfi_we_n_i,
   input  logic        dfi_cke_i,
   input  logic        dfi_odt_i,
   input  logic        dfi_reset_n_i,
   input  logic [31:0] dfi_wrdata_i,
   input  logic        dfi_wrdata_en_i,
   input  logic [3:0]  dfi_wrdata_mask_i,
   input  logic        dfi_rddata_en_i,
   output logic [31:0] dfi_rddata_o,
   output logic        dfi_rddata_valid_o,
   output logic [1:0]  dfi_rddata_dnv_o,
   output logic [3:0]  err_o
);

   localparam int MEM_WORDS = 1 << MEM_ADDR_W;

   typedef enum logic [2:0] {
      CMD_MRS  = 3'b000,
      CMD_REF  = 3'b001,
      CMD_PRE  = 3'b010,
      CMD_ACT  = 3'b011,
      CMD_WR   = 3'b100,
      CMD_RD   = 3'b101,
      CMD_ZQCL = 3'b110,
      CMD_NOP  = 3'b111
   } cmd_t;

   logic [7:0]            bank_open;
   logic [14:0]           bank_row [8];

   logic [MEM_ADDR_W-1:0] wq_addr [4];
   logic [MEM_ADDR_W-1:0] rq_addr [4];
   logic [1:0]            wq_head, rq_head;
   logic [2:0]            wq_cnt, rq_cnt;
   logic [1:0]            wr_beat, rd_beat;

   logic [31:0]           mem [MEM_WORDS];

   logic                  pipe_v [DDR_READ_LATENCY];
   logic [31:0]           pipe_d [DDR_READ_LATENCY];
   logic [3:0]            err_q;

   cmd_t                  cmd;
   logic                  cmd_en, any_open, sel_open;
   logic [14:0]           sel_row;
   logic [MEM_ADDR_W-1:0] base_addr, wr_addr, rd_addr;
   logic                  is_wr, is_rd;
   logic                  wr_do, wr_hit, rd_do, rd_hit;
   logic                  wq_pop, rq_pop, wq_push, rq_push;
   logic [1:0]            wq_tail, rq_tail;
   logic [3:0]            err_set;

   logic                  unused_odt;
   assign unused_odt = dfi_odt_i;

   always_comb begin
      cmd      = cmd_t'({dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i});
      cmd_en   = !dfi_cs_n_i && dfi_cke_i && dfi_reset_n_i;
      any_open = |bank_open;
      sel_open = bank_open[dfi_bank_i];
      // A closed bank still gets queued, addressed as row 0
      sel_row  = sel_open ? bank_row[dfi_bank_i] : 15'd0;
      base_addr = MEM_ADDR_W'({sel_row, dfi_bank_i, dfi_address_i[9:3], 2'b00});

      is_wr = cmd_en && (cmd == CMD_WR);
      is_rd = cmd_en && (cmd == CMD_RD);

      // Data beats are independent of cs_n/cke; only DRAM reset blocks them
      wr_do  = dfi_reset_n_i && dfi_wrdata_en_i;
      wr_hit = wr_do && (wq_cnt != 3'd0);
      rd_do  = dfi_reset_n_i && dfi_rddata_en_i;
      rd_hit = rd_do && (rq_cnt != 3'd0);

      wq_pop  = wr_hit && (wr_beat == 2'd3);
      rq_pop  = rd_hit && (rd_beat == 2'd3);
      // A full queue still accepts a push when its head retires the same cycle
      wq_push = is_wr && ((wq_cnt != 3'd4) || wq_pop);
      rq_push = is_rd && ((rq_cnt != 3'd4) || rq_pop);
      wq_tail = wq_head + wq_cnt[1:0];
      rq_tail = rq_head + rq_cnt[1:0];

      wr_addr = wq_addr[wq_head] + MEM_ADDR_W'(wr_beat);
      rd_addr = rq_addr[rq_head] + MEM_ADDR_W'(rd_beat);

      err_set[0] = cmd_en && (cmd == CMD_ACT) && sel_open;
      err_set[1] = (is_wr || is_rd) && !sel_open;
      err_set[2] = cmd_en && ((cmd == CMD_MRS) || (cmd == CMD_REF)) && any_open;
      err_set[3] = (is_wr && !wq_push) || (is_rd && !rq_push) ||
                   (wr_do && !wr_hit) || (rd_do && !rd_hit);
   end

   // Storage has no reset; writes land at the edge so a same-cycle read sees old data
   always_ff @(posedge clk_i) begin
      if (wr_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (!dfi_wrdata_mask_i[b])
               mem[wr_addr][8*b +: 8] <= dfi_wrdata_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bank_open <= '0;
         for (int i = 0; i < 8; i++) bank_row[i] <= '0;
         for (int i = 0; i < 4; i++) begin
            wq_addr[i] <= '0;
            rq_addr[i] <= '0;
         end
         wq_head <= '0;
         rq_head <= '0;
         wq_cnt  <= '0;
         rq_cnt  <= '0;
         wr_beat <= '0;
         rd_beat <= '0;
         for (int i = 0; i < DDR_READ_LATENCY; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_d[i] <= '0;
         end
         err_q <= '0;
      end else begin
         err_q <= err_q | err_set;
         if (!dfi_reset_n_i) begin
            // DRAM reset drops all in-flight activity but keeps storage and errors
            bank_open <= '0;
            for (int i = 0; i < 8; i++) bank_row[i] <= '0;
            wq_head <= '0;
            rq_head <= '0;
            wq_cnt  <= '0;
            rq_cnt  <= '0;
            wr_beat <= '0;
            rd_beat <= '0;
            for (int i = 0; i < DDR_READ_LATENCY; i++) begin
               pipe_v[i] <= 1'b0;
               pipe_d[i] <= '0;
            end
         end else begin
            if (cmd_en) begin
               case (cmd)
                  CMD_ACT: begin
                     bank_open[dfi_bank_i] <= 1'b1;
                     bank_row[dfi_bank_i]  <= dfi_address_i;
                  end
                  CMD_PRE: begin
                     if (dfi_address_i[10]) bank_open <= '0;
                     else                   bank_open[dfi_bank_i] <= 1'b0;
                  end
                  default: ;
               endcase
            end

            if (wq_push) wq_addr[wq_tail] <= base_addr;
            if (wq_pop)  wq_head <= wq_head + 2'd1;
            wq_cnt <= wq_cnt + 3'(wq_push) - 3'(wq_pop);
            if (wr_hit)  wr_beat <= wr_beat + 2'd1;

            if (rq_push) rq_addr[rq_tail] <= base_addr;
            if (rq_pop)  rq_head <= rq_head + 2'd1;
            rq_cnt <= rq_cnt + 3'(rq_push) - 3'(rq_pop);
            if (rd_hit)  rd_beat <= rd_beat + 2'd1;

            // Beat on an empty read queue still produces a valid zero word
            pipe_v[0] <= rd_do;
            pipe_d[0] <= rd_hit ? mem[rd_addr] : 32'h0;
            for (int i = 1; i < DDR_READ_LATENCY; i++) begin
               pipe_v[i] <= pipe_v[i-1];
               pipe_d[i] <= pipe_d[i-1];
            end
         end
      end
   end

   assign dfi_rddata_o       = pipe_d[DDR_READ_LATENCY-1];
   assign dfi_rddata_valid_o = pipe_v[DDR_READ_LATENCY-1];
   assign dfi_rddata_dnv_o   = 2'b00;
   assign err_o              = err_q;

endmodule

// File: tb/tb_ddr3_dfi_responder.sv
// tb/tb_ddr3_dfi_responder.sv - directed and randomized bench for ddr3_dfi_responder against a queue-based model
module tb_ddr3_dfi_responder;
   localparam int LAT   = 4;
   localparam int AW    = 10;
   localparam int WORDS = 1 << AW;

   logic        clk = 1'b0;
   logic        rst;
   logic [14:0] dfi_address;
   logic [2:0]  dfi_bank;
   logic        dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
   logic        dfi_cke, dfi_odt, dfi_reset_n;
   logic [31:0] dfi_wrdata;
   logic        dfi_wrdata_en;
   logic [3:0]  dfi_wrdata_mask;
   logic        dfi_rddata_en;
   logic [31:0] dfi_rddata;
   logic        dfi_rddata_valid;
   logic [1:0]  dfi_rddata_dnv;
   logic [3:0]  err;

   ddr3_dfi_responder #(.DDR_READ_LATENCY(LAT), .MEM_ADDR_W(AW)) dut (
      .clk_i(clk), .rst_i(rst),
      .dfi_address_i(dfi_address), .dfi_bank_i(dfi_bank),
      .dfi_cs_n_i(dfi_cs_n), .dfi_ras_n_i(dfi_ras_n), .dfi_cas_n_i(dfi_cas_n), .dfi_we_n_i(dfi_we_n),
      .dfi_cke_i(dfi_cke), .dfi_odt_i(dfi_odt), .dfi_reset_n_i(dfi_reset_n),
      .dfi_wrdata_i(dfi_wrdata), .dfi_wrdata_en_i(dfi_wrdata_en), .dfi_wrdata_mask_i(dfi_wrdata_mask),
      .dfi_rddata_en_i(dfi_rddata_en),
      .dfi_rddata_o(dfi_rddata), .dfi_rddata_valid_o(dfi_rddata_valid), .dfi_rddata_dnv_o(dfi_rddata_dnv),
      .err_o(err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Reference model state
   bit          m_open [8];
   int          m_row  [8];
   int          wq[$];
   int          rq[$];
   int          m_wbeat, m_rbeat;
   logic [31:0] m_mem   [WORDS];
   logic [3:0]  m_known [WORDS];
   logic [3:0]  m_err;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic [31:0] kmask;
   } exp_t;
   exp_t        expq[$];
   logic [31:0] seen[$];

   function automatic int word_addr(int bank, int addr, int beat);
      longint row = m_open[bank] ? longint'(m_row[bank]) : 64'd0;
      longint a   = row * 4096 + longint'(bank) * 512 + longint'((addr >> 3) & 127) * 4 + longint'(beat);
      return int'(a % WORDS);
   endfunction

   function automatic logic [31:0] known_mask(logic [3:0] k);
      logic [31:0] m = '0;
      for (int b = 0; b < 4; b++) if (k[b]) m[8*b +: 8] = 8'hFF;
      return m;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin m_open[i] = 0; m_row[i] = 0; end
      wq.delete(); rq.delete(); expq.delete();
      m_wbeat = 0; m_rbeat = 0; m_err = 4'h0;
   endtask

   // Effect of the inputs currently applied, taken at the coming rising edge
   task automatic model_edge();
      int   a;
      bit   any;
      exp_t e;
      if (!dfi_reset_n) begin
         for (int i = 0; i < 8; i++) begin m_open[i] = 0; m_row[i] = 0; end
         wq.delete(); rq.delete(); expq.delete();
         m_wbeat = 0; m_rbeat = 0;
         return;
      end
      // Reads see storage before this cycle's write
      if (dfi_rddata_en) begin
         e.due = cyc + LAT;
         if (rq.size() == 0) begin
            e.data = 32'h0; e.kmask = 32'hFFFF_FFFF; m_err[3] = 1'b1;
         end else begin
            a = (rq[0] + m_rbeat) % WORDS;
            e.data = m_mem[a]; e.kmask = known_mask(m_known[a]);
            m_rbeat++;
            if (m_rbeat == 4) begin m_rbeat = 0; void'(rq.pop_front()); end
         end
         expq.push_back(e);
      end
      if (dfi_wrdata_en) begin
         if (wq.size() == 0) m_err[3] = 1'b1;
         else begin
            a = (wq[0] + m_wbeat) % WORDS;
            for (int b = 0; b < 4; b++) begin
               if (!dfi_wrdata_mask[b]) begin
                  m_mem[a][8*b +: 8] = dfi_wrdata[8*b +: 8];
                  m_known[a][b] = 1'b1;
               end
            end
            m_wbeat++;
            if (m_wbeat == 4) begin m_wbeat = 0; void'(wq.pop_front()); end
         end
      end
      if (!dfi_cs_n && dfi_cke) begin
         any = 0;
         for (int i = 0; i < 8; i++) any |= m_open[i];
         case ({dfi_ras_n, dfi_cas_n, dfi_we_n})
            3'b000, 3'b001: if (any) m_err[2] = 1'b1;
            3'b010: begin
               if (dfi_address[10]) for (int i = 0; i < 8; i++) m_open[i] = 0;
               else m_open[dfi_bank] = 0;
            end
            3'b011: begin
               if (m_open[dfi_bank]) m_err[0] = 1'b1;
               m_open[dfi_bank] = 1; m_row[dfi_bank] = int'(dfi_address);
            end
            3'b100, 3'b101: begin
               if (!m_open[dfi_bank]) m_err[1] = 1'b1;
               a = word_addr(int'(dfi_bank), int'(dfi_address), 0);
               if (dfi_we_n) begin
                  if (rq.size() < 4) rq.push_back(a); else m_err[3] = 1'b1;
               end else begin
                  if (wq.size() < 4) wq.push_back(a); else m_err[3] = 1'b1;
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic check_outputs();
      bit   ev = 0;
      exp_t e;
      if (expq.size() > 0 && expq[0].due == cyc) begin e = expq.pop_front(); ev = 1; end
      vectors++;
      assert (dfi_rddata_valid === ev) else begin
         miscompares++;
         $error("FAIL valid cyc=%0d observed=%b expected=%b", cyc, dfi_rddata_valid, ev);
      end
      if (ev) begin
         vectors++;
         assert ((dfi_rddata & e.kmask) === (e.data & e.kmask)) else begin
            miscompares++;
            $error("FAIL rddata cyc=%0d observed=%h expected=%h", cyc, dfi_rddata, e.data);
         end
         seen.push_back(dfi_rddata);
      end
      vectors++;
      assert (err === m_err) else begin
         miscompares++;
         $error("FAIL err cyc=%0d observed=%b expected=%b", cyc, err, m_err);
      end
   endtask

   task automatic set_idle();
      dfi_cs_n = 0; dfi_ras_n = 1; dfi_cas_n = 1; dfi_we_n = 1;
      dfi_cke = 1; dfi_reset_n = 1; dfi_odt = 0;
      dfi_wrdata_en = 0; dfi_rddata_en = 0; dfi_wrdata_mask = 4'h0;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk); #1;
      cyc++;
      check_outputs();
      set_idle();
   endtask

   task automatic drive_cmd(logic [2:0] c, int bank, int addr);
      {dfi_ras_n, dfi_cas_n, dfi_we_n} = c;
      dfi_bank = 3'(bank);
      dfi_address = 15'(addr);
   endtask

   task automatic act(int b, int row);  drive_cmd(3'b011, b, row); step(); endtask
   task automatic pre(int b, bit all);  drive_cmd(3'b010, b, all ? 1024 : 0); step(); endtask
   task automatic wr(int b, int col);   drive_cmd(3'b100, b, col); step(); endtask
   task automatic rd(int b, int col);   drive_cmd(3'b101, b, col); step(); endtask
   task automatic refresh();            drive_cmd(3'b001, 0, 0); step(); endtask
   task automatic wbeat(logic [31:0] d, logic [3:0] m);
      dfi_wrdata = d; dfi_wrdata_mask = m; dfi_wrdata_en = 1; step();
   endtask
   task automatic rbeat();              dfi_rddata_en = 1; step(); endtask
   task automatic idle(int n);          for (int i = 0; i < n; i++) step(); endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reset pulse placed mid-cycle, away from the clock edge
   task automatic rst_pulse();
      rst = 1; #1;
      model_reset();
      chk("async_rst_valid", 32'(dfi_rddata_valid), 32'h0);
      chk("async_rst_err", 32'(err), 32'h0);
      chk("async_rst_data", dfi_rddata, 32'h0);
      #1; rst = 0;
   endtask

   initial begin
      int r;
      for (int i = 0; i < WORDS; i++) begin m_mem[i] = '0; m_known[i] = '0; end
      set_idle();
      dfi_address = '0; dfi_bank = '0; dfi_wrdata = '0;
      rst = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", 32'(dfi_rddata_valid), 32'h0);
      chk("reset_data", dfi_rddata, 32'h0);
      chk("reset_err", 32'(err), 32'h0);
      chk("reset_dnv", 32'(dfi_rddata_dnv), 32'h0);
      rst = 0;

      // Basic write/read round trip
      act(0, 5); wr(0, 0);
      wbeat(32'h11, 4'h0); wbeat(32'h22, 4'h0); wbeat(32'h33, 4'h0); wbeat(32'h44, 4'h0);
      rd(0, 0);
      seen.delete();
      repeat (4) rbeat();
      idle(LAT + 1);
      chk("rt_count", 32'(seen.size()), 32'd4);
      if (seen.size() == 4) begin
         chk("rt_beat0", seen[0], 32'h11); chk("rt_beat1", seen[1], 32'h22);
         chk("rt_beat2", seen[2], 32'h33); chk("rt_beat3", seen[3], 32'h44);
      end
      chk("rt_err", 32'(err), 32'h0);

      // Byte mask
      wr(0, 8);
      wbeat(32'h1234_5678, 4'h0);
      repeat (3) wbeat($urandom, 4'h0);
      wr(0, 8);
      wbeat(32'hFFFF_FFFF, 4'b0011);
      repeat (3) wbeat($urandom, 4'hF);
      rd(0, 8);
      seen.delete();
      repeat (4) rbeat();
      idle(LAT + 1);
      chk("mask_count", 32'(seen.size()), 32'd4);
      if (seen.size() > 0) chk("mask_merge", seen[0], 32'hFFFF_5678);

      // Precharge-all then refresh is clean; refresh with a bank open flags
      act(1, 3); act(2, 4);
      pre(0, 1);
      refresh();
      chk("ref_closed", 32'(err[2]), 32'h0);
      act(1, 7);
      refresh();
      chk("ref_open", 32'(err[2]), 32'h1);
      pre(0, 1);

      // Double ACT and access to a never-opened bank
      act(3, 1); act(3, 2);
      chk("act_twice", 32'(err[0]), 32'h1);
      rd(4, 16);
      chk("rd_closed", 32'(err[1]), 32'h1);
      repeat (4) rbeat();
      idle(LAT + 1);
      chk("sticky", 32'(err[1:0]), 32'h3);

      // Write queue overflow then drain in order
      act(0, 9);
      for (int i = 0; i < 5; i++) wr(0, 8 * i);
      chk("wq_overflow", 32'(err[3]), 32'h1);
      for (int i = 0; i < 16; i++) wbeat($urandom, 4'(($urandom_range(0, 3) == 0) ? $urandom : 0));
      for (int i = 0; i < 4; i++) rd(0, 8 * i);
      repeat (16) rbeat();
      idle(LAT + 1);

      // Reset during the second read beat
      act(0, 3); wr(0, 16);
      repeat (4) wbeat($urandom, 4'h0);
      rd(0, 16);
      rbeat(); rbeat();
      rst_pulse();
      idle(LAT + 1);
      seen.delete();
      rbeat();
      idle(LAT);
      chk("empty_beat_count", 32'(seen.size()), 32'd1);
      if (seen.size() > 0) chk("empty_beat_zero", seen[0], 32'h0);
      chk("empty_beat_err", 32'(err), 32'h8);
      act(0, 3); wr(0, 24);
      wbeat(32'hA5A5_0001, 4'h0); wbeat(32'hA5A5_0002, 4'h0);
      wbeat(32'hA5A5_0003, 4'h0); wbeat(32'hA5A5_0004, 4'h0);
      rd(0, 24);
      seen.delete();
      repeat (4) rbeat();
      idle(LAT + 1);
      chk("post_rst_count", 32'(seen.size()), 32'd4);
      if (seen.size() == 4) begin
         chk("post_rst_b0", seen[0], 32'hA5A5_0001);
         chk("post_rst_b3", seen[3], 32'hA5A5_0004);
      end

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 11);
         case (r)
            0:    drive_cmd(3'b011, $urandom_range(0, 3), $urandom_range(0, 32767));
            1:    drive_cmd(3'b010, $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? 1024 : 0);
            2, 3: drive_cmd(3'b100, $urandom_range(0, 3), $urandom_range(0, 1023));
            4, 5: drive_cmd(3'b101, $urandom_range(0, 3), $urandom_range(0, 1023));
            6:    drive_cmd(3'b001, 0, 0);
            7:    drive_cmd(3'b110, 0, 0);
            default: drive_cmd(3'b111, 0, 0);
         endcase
         dfi_cs_n        = ($urandom_range(0, 9) == 0);
         dfi_cke         = ($urandom_range(0, 19) != 0);
         dfi_reset_n     = ($urandom_range(0, 59) != 0);
         dfi_wrdata_en   = $urandom_range(0, 1) == 1;
         dfi_rddata_en   = $urandom_range(0, 1) == 1;
         dfi_wrdata      = $urandom;
         dfi_wrdata_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         step();
      end
      idle(LAT + 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ddr3_dfi_responder.md
DDR3_DFI_RESPONDER -- requirements
Module: ddr3_dfi_responder

Interface
REQ-001 SHALL have parameter DDR_READ_LATENCY, default 4, cycles from dfi_rddata_en_i beat to dfi_rddata_valid_o beat.
REQ-002 SHALL have parameter MEM_ADDR_W, default 10, log2 of 32-bit storage words.
REQ-003 SHALL have one clock and one reset: clk_i is the single clock; rst_i is the reset, asynchronous and active-high.
REQ-004 clk_i  input  1  sole clock, all logic on rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 dfi_address_i  input  15  row on ACT, column on RD/WR, A10 = precharge-all on PRE.
REQ-007 dfi_bank_i  input  3  bank select.
REQ-008 dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i  input  1 each  command strobes.
REQ-009 dfi_cke_i, dfi_odt_i, dfi_reset_n_i  input  1 each  clock enable, ODT (ignored), DRAM reset (active-low).
REQ-010 dfi_wrdata_i  input  32  write beat.
REQ-011 dfi_wrdata_en_i  input  1  write beat valid.
REQ-012 dfi_wrdata_mask_i  input  4  per-byte mask, 1 = byte not written.
REQ-013 dfi_rddata_en_i  input  1  read beat request.
REQ-014 dfi_rddata_o  output  32  read beat.
REQ-015 dfi_rddata_valid_o  output  1  read beat valid.
REQ-016 dfi_rddata_dnv_o  output  2  data-not-valid, tied 2'b00.
REQ-017 err_o  output  4  sticky protocol errors: [0] ACT to open bank, [1] RD/WR to closed bank, [2] REF/MRS with bank open, [3] data beat with empty queue.

Function
REQ-018 Command SHALL be decoded only when dfi_cs_n_i=0, dfi_cke_i=1 and dfi_reset_n_i=1; {ras_n,cas_n,we_n}: 000 MRS, 001 REF, 010 PRE, 011 ACT, 100 WR, 101 RD, 110 ZQCL, 111 NOP.
REQ-019 Per bank: open flag + 15-bit row register; ACT sets open and loads row; PRE clears selected bank, or all banks if address[10]=1.
REQ-020 MRS, ZQCL and NOP SHALL change no state except err_o[2] for MRS with any bank open; REF with any bank open sets err_o[2].
REQ-021 Burst word address SHALL be low MEM_ADDR_W bits of {row, bank, column[9:3], beat[1:0]}; each RD/WR is 4 beats of 32 bits.
REQ-022 WR SHALL push base address into 4-deep write queue; each dfi_wrdata_en_i beat writes unmasked bytes at head + beat counter; 4th beat pops entry, counter wraps to 0.
REQ-023 RD SHALL push base address into 4-deep read queue; each dfi_rddata_en_i beat reads head + beat counter; 4th beat pops.
REQ-024 Read beat data and a valid bit SHALL pass through a DDR_READ_LATENCY-stage pipeline; dfi_rddata_valid_o asserts exactly DDR_READ_LATENCY cycles after each dfi_rddata_en_i, beat order preserved, back-to-back beats allowed.
REQ-025 RD/WR to closed bank sets err_o[1] and is still queued using row 0.
REQ-026 Push to full queue SHALL be dropped and set err_o[3]; data beat on empty queue sets err_o[3], writes nothing, returns 32'h0 with valid.
REQ-027 Same-cycle push and pop on one queue SHALL both take effect; occupancy unchanged.
REQ-028 Read beat of an address written in the same cycle SHALL return old data (read-before-write).
REQ-029 dfi_reset_n_i=0 SHALL clear bank state, queues, beat counters and pipeline; storage and err_o retained.

Reset
REQ-030 rst_i SHALL asynchronously clear bank flags, rows, queues, counters, pipeline, err_o=0, dfi_rddata_valid_o=0, dfi_rddata_o=0; storage not reset.
REQ-031 Reset asserted mid-burst SHALL abandon the burst; first post-reset beat with empty queue follows REQ-026.

Verification
REQ-032 ACT b0 row 5; WR col 0; 4 wrdata beats 11,22,33,44 mask 0; RD col 0; 4 rddata_en beats -> valid 4 cycles after each, data 11,22,33,44, err_o=0.
REQ-033 WR beat with mask 4'b0011 over 32'hFFFFFFFF onto 32'h12345678 -> read returns 32'hFFFF5678.
REQ-034 ACT b3 twice -> err_o[0]=1; RD b4 never opened -> err_o[1]=1; error bits stay set until rst_i.
REQ-035 Five WR commands, no data -> fifth dropped, err_o[3]=1; then 16 wrdata beats consume 4 entries in order.
REQ-036 PRE A10=1 after ACT b1,b2 -> REF causes no err_o[2]; REF with b1 open -> err_o[2]=1.
REQ-037 rst_i pulse during 2nd read beat -> valid=0 next cycle, queues empty, later RD/data round-trip correct.
